// File: rtl/dmem_io_bridge.sv
// rtl/dmem_io_bridge.sv - data-memory bridge: RAM pass-through plus button, timer, score and LFSR registers
module dmem_io_bridge #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] q_dmem,
  output logic        ram_wEn,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut,
  input  logic        btn_jump,
  input  logic        btn_duck,
  output logic [31:0] score
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic          sel_ram;
  logic          sel_io;
  logic [2:0]    offset;
  logic          io_wr;
  logic          wr_timer;
  logic          wr_score;
  logic          wr_rand;
  logic          ev_clear;
  logic          tick;
  logic          lfsr_fb;
  logic          jump_rise;
  logic          duck_rise;
  logic [31:0]   io_rdata;

  // [0] first sync stage, [1] synchronized level, [2] previous level for edge detect
  logic [2:0]    jump_sync;
  logic [2:0]    duck_sync;
  logic          jump_ev;
  logic          duck_ev;
  logic [31:0]   timer;
  logic [PW-1:0] presc;
  logic [15:0]   lfsr;
  logic [31:0]   score_q;
  logic          rd_ram_q;
  logic          rd_io_q;
  logic [31:0]   io_rdata_q;

  assign sel_ram    = (address_dmem[31:12] == 20'h00000);
  assign sel_io     = (address_dmem[31:12] == 20'h00001);
  assign offset     = address_dmem[2:0];
  assign ram_wEn    = wren & sel_ram & ~reset;
  assign ram_addr   = address_dmem[11:0];
  assign ram_dataIn = data;

  assign io_wr     = wren & sel_io;
  assign wr_timer  = io_wr & (offset == 3'd2);
  assign wr_score  = io_wr & (offset == 3'd3);
  assign wr_rand   = io_wr & (offset == 3'd4);
  assign ev_clear  = sel_io & ~wren & (offset == 3'd1);
  assign tick      = (presc == PRESC_MAX);
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign jump_rise = jump_sync[1] & ~jump_sync[2];
  assign duck_rise = duck_sync[1] & ~duck_sync[2];

  always_comb begin
    io_rdata = '0;
    case (offset)
      3'd0:    io_rdata = {30'b0, duck_sync[1], jump_sync[1]};
      3'd1:    io_rdata = {30'b0, duck_ev, jump_ev};
      3'd2:    io_rdata = timer;
      3'd3:    io_rdata = score_q;
      3'd4:    io_rdata = {16'b0, lfsr};
      default: io_rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      jump_sync  <= '0;
      duck_sync  <= '0;
      jump_ev    <= 1'b0;
      duck_ev    <= 1'b0;
      timer      <= '0;
      presc      <= '0;
      lfsr       <= LFSR_SEED;
      score_q    <= '0;
      rd_ram_q   <= 1'b0;
      rd_io_q    <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      jump_sync <= {jump_sync[1:0], btn_jump};
      duck_sync <= {duck_sync[1:0], btn_duck};
      // a new edge in the same cycle as a clearing read keeps the bit set
      jump_ev   <= (jump_ev & ~ev_clear) | jump_rise;
      duck_ev   <= (duck_ev & ~ev_clear) | duck_rise;

      if (wr_timer) begin
        timer <= data;
        presc <= '0;
      end else if (tick) begin
        timer <= timer + 32'd1;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      if (wr_score)
        score_q <= data;

      if (wr_rand)
        lfsr <= (data[15:0] == 16'h0000) ? LFSR_SEED : data[15:0];
      else
        lfsr <= {lfsr[14:0], lfsr_fb};

      rd_ram_q   <= sel_ram;
      rd_io_q    <= sel_io;
      io_rdata_q <= sel_io ? io_rdata : '0;
    end
  end

  assign q_dmem = rd_ram_q ? ram_dataOut :
                  rd_io_q  ? io_rdata_q  : 32'h0;
  assign score  = score_q;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// tb/tb_dmem_io_bridge.sv - randomized and directed bench for dmem_io_bridge against a behavioural model
module tb_dmem_io_bridge;

  localparam int unsigned TICK_DIV = 4;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [31:0] IO       = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_dmem;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut = 32'h0;
  logic        btn_jump;
  logic        btn_duck;
  logic [31:0] score;

  dmem_io_bridge #(.TICK_DIV(TICK_DIV), .LFSR_SEED(SEED)) dut (
    .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem),
    .data(data), .q_dmem(q_dmem), .ram_wEn(ram_wEn), .ram_addr(ram_addr),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut), .btn_jump(btn_jump),
    .btn_duck(btn_duck), .score(score)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int shown = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (shown < 40) begin
        shown++;
        $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // RAM attached to the bridge: one-cycle read, read-before-write
  logic [31:0] tmem [4096];
  initial for (int i = 0; i < 4096; i++) tmem[i] = 32'h0;
  always @(posedge clock) begin
    ram_dataOut <= tmem[ram_addr];
    if (ram_wEn) tmem[ram_addr] <= ram_dataIn;
  end

  // Behavioural model: state advanced once per edge from the inputs sampled there
  bit          mv = 1'b0;
  bit [31:0]   mmem [4096];
  bit [31:0]   m_q, m_score, m_timer;
  int          m_presc;
  bit [15:0]   m_lfsr;
  bit          m_jev, m_dev;
  bit [2:0]    hj, hd;   // button samples from 1, 2, 3 edges ago

  initial for (int i = 0; i < 4096; i++) mmem[i] = 32'h0;

  function automatic bit [15:0] lfsr_step(input bit [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  always @(posedge clock) begin : model
    bit       is_ram, is_io, rj, rd, clr;
    bit [2:0] off;
    is_ram = (address_dmem[31:12] == 20'h0);
    is_io  = (address_dmem[31:12] == 20'h1);
    off    = address_dmem[2:0];
    if (reset) begin
      mv = 1'b1; m_q = 0; m_score = 0; m_timer = 0; m_presc = 0;
      m_lfsr = SEED; m_jev = 0; m_dev = 0; hj = 0; hd = 0;
    end else begin
      rj = hj[1] & ~hj[2];
      rd = hd[1] & ~hd[2];
      if (is_ram) m_q = mmem[address_dmem[11:0]];
      else if (is_io) begin
        case (off)
          3'd0:    m_q = {30'b0, hd[1], hj[1]};
          3'd1:    m_q = {30'b0, m_dev, m_jev};
          3'd2:    m_q = m_timer;
          3'd3:    m_q = m_score;
          3'd4:    m_q = {16'b0, m_lfsr};
          default: m_q = 0;
        endcase
      end else m_q = 0;
      if (is_ram && wren) mmem[address_dmem[11:0]] = data;
      clr   = is_io && !wren && off == 3'd1;
      m_jev = (m_jev && !clr) || rj;
      m_dev = (m_dev && !clr) || rd;
      hj    = {hj[1:0], btn_jump};
      hd    = {hd[1:0], btn_duck};
      if (is_io && wren && off == 3'd2) begin
        m_timer = data;
        m_presc = 0;
      end else begin
        m_presc++;
        if (m_presc == TICK_DIV) begin
          m_presc = 0;
          m_timer++;
        end
      end
      if (is_io && wren && off == 3'd3) m_score = data;
      if (is_io && wren && off == 3'd4) m_lfsr = (data[15:0] == 0) ? SEED : data[15:0];
      else m_lfsr = lfsr_step(m_lfsr);
    end
  end

  always @(negedge clock) begin
    if (mv) begin
      check("q_dmem", q_dmem, m_q);
      check("score", score, m_score);
      check("ram_wEn", 32'(ram_wEn), 32'(wren & (address_dmem[31:12] == 20'h0) & ~reset));
      check("ram_addr", 32'(ram_addr), 32'(address_dmem[11:0]));
      check("ram_dataIn", ram_dataIn, data);
    end
  end

  logic last_wen;
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    reset = r; wren = w; address_dmem = a; data = d;
    @(negedge clock);
    last_wen = ram_wEn;
    @(posedge clock);
    #1;
  endtask
  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b0, a, 32'h0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d);
  endtask

  initial begin
    logic [31:0] first, v, a;
    int zeros, reps;
    btn_jump = 0; btn_duck = 0;
    reset = 1; wren = 1; address_dmem = 32'h5; data = 32'hDEAD_BEEF;
    @(posedge clock); #1;

    step(1'b1, 1'b1, 32'h5, 32'hDEAD_BEEF);
    check("reset_ram_wEn", 32'(last_wen), 32'h0);
    check("reset_q", q_dmem, 32'h0);
    check("reset_score", score, 32'h0);

    wr(32'h5, 32'h1234);
    check("ram_wEn_pulse", 32'(last_wen), 32'h1);
    rd(32'h5);
    check("ram_wEn_idle", 32'(last_wen), 32'h0);
    check("ram_read", q_dmem, 32'h1234);

    step(1'b1, 1'b0, 32'h2000, 32'h0);
    for (int i = 0; i < 12; i++) rd(32'h2000);
    rd(IO + 2);
    check("timer_13", q_dmem, 32'h3);
    wr(IO + 2, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) rd(32'h2000);
    rd(IO + 2);
    check("timer_max", q_dmem, 32'hFFFF_FFFF);
    rd(IO + 2);
    check("timer_wrap", q_dmem, 32'h0);
    wr(IO + 2, 32'd100);
    check("timer_rd_on_wr", q_dmem, 32'h0);
    rd(IO + 2);
    check("timer_load", q_dmem, 32'd100);

    wr(IO + 3, 32'd42);
    check("score_wr", score, 32'd42);
    rd(IO + 3);
    check("score_rd", q_dmem, 32'd42);
    step(1'b1, 1'b0, IO + 3, 32'h0);
    check("score_reset", score, 32'h0);
    check("q_after_reset", q_dmem, 32'h0);

    btn_jump = 1;
    rd(32'h2000);
    rd(32'h2000);
    rd(IO + 1);
    check("ev_not_yet", q_dmem, 32'h0);
    rd(IO + 1);
    check("ev_set_wins", q_dmem, 32'h1);
    rd(IO + 1);
    check("ev_cleared", q_dmem, 32'h0);
    rd(IO + 0);
    check("btn_level", q_dmem, 32'h1);
    for (int i = 0; i < 5; i++) rd(32'h2000);
    btn_jump = 0;
    for (int i = 0; i < 4; i++) rd(32'h2000);

    rd(32'h2000);
    check("unmapped_rd", q_dmem, 32'h0);
    rd(IO + 6);
    check("io_off6_rd", q_dmem, 32'h0);
    wr(32'h2000, 32'h77);
    check("unmapped_wr_wEn", 32'(last_wen), 32'h0);
    wr(IO + 6, 32'h55);
    wr(IO + 5, 32'h9);
    rd(32'h0);
    check("ram0_untouched", q_dmem, 32'h0);
    rd(IO + 3);
    check("score_untouched", q_dmem, 32'h0);

    wr(IO + 4, 32'hFFFF_0000);
    zeros = 0; reps = 0; first = 32'h0;
    for (int i = 0; i <= 65535; i++) begin
      rd(IO + 4);
      v = q_dmem;
      if (i == 0) begin
        first = v;
        check("lfsr_seed", v, 32'h0000_ACE1);
      end else begin
        if (i == 1) check("lfsr_next", v, 32'h0000_59C3);
        if (v == 32'h0) zeros++;
        if (i < 65535 && v == first) reps++;
        if (i == 65535) check("lfsr_period", v, first);
      end
    end
    check("lfsr_nonzero", 32'(zeros), 32'h0);
    check("lfsr_no_early_repeat", 32'(reps), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, 15));
        4, 5, 6, 7: a = IO + 32'($urandom_range(0, 15));
        8:          a = 32'h2000 + 32'($urandom_range(0, 7));
        default:    a = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) btn_jump = ~btn_jump;
      if ($urandom_range(0, 7) == 0) btn_duck = ~btn_duck;
      v = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, a, v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
